interrupt_request_controller: RTL and testbench

- Collects up to N_SRC peripheral interrupt requests and latches them as pending.
- Applies a mask and fixed priority, then drives the INT0/INT1 request lines into the CPU interrupt state machine.
- Tracks service nesting from the CPU's vector-load and RETI strobes.
- Exposes pending, mask, active-source and software-trigger registers on the CPU register bus.

---
 rtl/interrupt_request_controller_pkg.sv | 29 ++
 rtl/interrupt_request_controller_irq_edge_detect.sv | 31 +++
 rtl/interrupt_request_controller.sv | 175 +++++++++++++++++
 tb/tb_interrupt_request_controller.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_request_controller_pkg.sv
// Shared constants for the interrupt request controller: FSM state
// encodings, register addresses and the lowest-set-index helper.
// Ports: none (package).
package interrupt_request_controller_pkg;

  // Service state encodings (2-bit, legacy compatible)
  localparam logic [1:0] INTC_STATE_IDLE   = 2'd0;
  localparam logic [1:0] INTC_STATE_SVC1   = 2'd1;
  localparam logic [1:0] INTC_STATE_SVC0   = 2'd2;
  localparam logic [1:0] INTC_STATE_SVC1_0 = 2'd3;

  // Register map
  localparam logic [2:0] INTC_ADDR_PEND   = 3'd0;
  localparam logic [2:0] INTC_ADDR_MASK   = 3'd1;
  localparam logic [2:0] INTC_ADDR_ACTIVE = 3'd2;
  localparam logic [2:0] INTC_ADDR_SWTRIG = 3'd3;
  localparam logic [2:0] INTC_ADDR_LEVEL  = 3'd4;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] intc_lowest_idx(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_request_controller_irq_edge_detect.sv
// Per-bit 2-flop synchroniser with rising-edge pulse and level output.
// Ports: CLK, RESET (async, active-high), irq_i raw request,
//        edge_o one-cycle pulse on a synchronised rise, level_o synchronised level.
module irq_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic irq_i,
  output logic edge_o,
  output logic level_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o  = sync2_q & ~prev_q;
  assign level_o = sync2_q;

endmodule

// File: rtl/interrupt_request_controller.sv
// Interrupt request controller: latches peripheral requests as pending, applies
// mask and fixed priority, drives INT0/INT1 and tracks nested service from the
// CPU's vector-load (ACK0/ACK1) and RETI strobes, all qualified by COMMIT.
// Ports: CLK, RESET (async, active-high), COMMIT, IRQ[N_SRC], ACK0, ACK1, RETI,
//        WR, RD, ADDR[3], WDATA/RDATA[DATA_W], INT0, INT1, ACTIVE_IDX[4].
// Optional: INT_LEVEL_MODE_EN adds the LEVEL register (ADDR 4) for level-sensitive sources.
module interrupt_request_controller #(
  parameter int N_SRC  = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              COMMIT,
  input  logic [N_SRC-1:0]  IRQ,
  input  logic              ACK0,
  input  logic              ACK1,
  input  logic              RETI,
  input  logic              WR,
  input  logic              RD,
  input  logic [2:0]        ADDR,
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              INT0,
  output logic              INT1,
  output logic [3:0]        ACTIVE_IDX
);
  import interrupt_request_controller_pkg::*;

  logic [N_SRC-1:0]  pend_q, pend_d, mask_q;
  logic [N_SRC-1:0]  irq_edge, irq_lvl;
  logic [N_SRC-1:0]  wr_src, sw_set, w1c_clr, ack_clr;
  logic [N_SRC-1:0]  masked, lowest_bit;
  logic [15:0]       masked_ext;
  logic [3:0]        win;
  logic              int1_raw;
  logic [1:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              int0_q, int1_q;
  logic [DATA_W-1:0] rdata_q, rd_val;
  logic              wr_cmt, rd_cmt;
  logic              unused_sigs;
`ifdef INT_LEVEL_MODE_EN
  logic [N_SRC-1:0]  level_q;
`endif

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_edge_detect u_edge (
      .CLK     (CLK),
      .RESET   (RESET),
      .irq_i   (IRQ[i]),
      .edge_o  (irq_edge[i]),
      .level_o (irq_lvl[i])
    );
  end

  assign wr_cmt  = WR & COMMIT;
  assign rd_cmt  = RD & COMMIT;
  assign wr_src  = WDATA[N_SRC-1:0];
  assign sw_set  = (wr_cmt && ADDR == INTC_ADDR_SWTRIG) ? wr_src : '0;
  assign w1c_clr = (wr_cmt && ADDR == INTC_ADDR_PEND)   ? wr_src : '0;

  // Source 0 is non-maskable and never competes for INT1.
  assign masked     = pend_q & {mask_q[N_SRC-1:1], 1'b0};
  assign lowest_bit = masked & (~masked + N_SRC'(1));
  assign int1_raw   = |masked;

  always_comb begin
    masked_ext = '0;
    masked_ext[N_SRC-1:0] = masked;
  end
  assign win = intc_lowest_idx(masked_ext);

  // Service FSM: acts at most once per COMMIT even if ACK/RETI are held.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ack_clr = '0;
    if (COMMIT) begin
      case (state_q)
        INTC_STATE_IDLE: begin
          if (ACK0) begin
            state_d    = INTC_STATE_SVC0;
            ack_clr[0] = 1'b1;
          end else if (ACK1) begin
            // Empty masked vector gives a spurious entry: idx 0, valid 0.
            state_d = INTC_STATE_SVC1;
            idx_d   = win;
            valid_d = int1_raw;
            ack_clr = lowest_bit;
          end
        end
        INTC_STATE_SVC1: begin
          if (ACK0) begin
            state_d    = INTC_STATE_SVC1_0;
            ack_clr[0] = 1'b1;
          end else if (RETI) begin
            state_d = INTC_STATE_IDLE;
            valid_d = 1'b0;
          end
        end
        INTC_STATE_SVC1_0: if (RETI) state_d = INTC_STATE_SVC1;
        INTC_STATE_SVC0:   if (RETI) state_d = INTC_STATE_IDLE;
        default:           state_d = INTC_STATE_IDLE;
      endcase
    end
  end

  // Sets (edge or SWTRIG) win over W1C and ack-clear on the same bit.
  always_comb begin
    pend_d = (pend_q & ~(w1c_clr | ack_clr)) | irq_edge | sw_set;
`ifdef INT_LEVEL_MODE_EN
    for (int i = 0; i < N_SRC; i++) begin
      if (level_q[i]) pend_d[i] = irq_lvl[i];
    end
`endif
  end

  always_comb begin
    rd_val = '0;
    case (ADDR)
      INTC_ADDR_PEND:   rd_val[N_SRC-1:0] = pend_q;
      INTC_ADDR_MASK:   rd_val[N_SRC-1:0] = mask_q;
      INTC_ADDR_ACTIVE: begin
        rd_val[DATA_W-1] = valid_q;
        rd_val[3:0]      = idx_q;
      end
`ifdef INT_LEVEL_MODE_EN
      INTC_ADDR_LEVEL:  rd_val[N_SRC-1:0] = level_q;
`else
      INTC_ADDR_LEVEL:  rd_val = '0;
`endif
      default:          rd_val = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_q  <= '0;
      mask_q  <= '0;
      state_q <= INTC_STATE_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      int0_q  <= 1'b0;
      int1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      int0_q  <= pend_q[0] && state_q != INTC_STATE_SVC0 && state_q != INTC_STATE_SVC1_0;
      int1_q  <= int1_raw && state_q == INTC_STATE_IDLE;
      if (wr_cmt && ADDR == INTC_ADDR_MASK) mask_q <= wr_src;
      if (rd_cmt) rdata_q <= rd_val;
    end
  end

`ifdef INT_LEVEL_MODE_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) level_q <= '0;
    else if (wr_cmt && ADDR == INTC_ADDR_LEVEL) level_q <= wr_src;
  end
`endif

  // Upper WDATA bits and (in edge-only builds) the level outputs are not consumed.
  assign unused_sigs = ^{WDATA, irq_lvl};

  assign RDATA      = rdata_q;
  assign INT0       = int0_q;
  assign INT1       = int1_q;
  assign ACTIVE_IDX = idx_q;

endmodule

// File: tb/tb_interrupt_request_controller.sv
module tb_interrupt_request_controller;
  localparam int N  = 8;
  localparam int DW = 16;

  localparam logic [2:0] A_PEND   = 3'd0;
  localparam logic [2:0] A_MASK   = 3'd1;
  localparam logic [2:0] A_ACTIVE = 3'd2;
  localparam logic [2:0] A_SWTRIG = 3'd3;
  localparam logic [2:0] A_LEVEL  = 3'd4;

  logic          CLK = 1'b0;
  logic          RESET, COMMIT, ACK0, ACK1, RETI, WR, RD;
  logic [N-1:0]  IRQ;
  logic [2:0]    ADDR;
  logic [DW-1:0] WDATA, RDATA;
  logic          INT0, INT1;
  logic [3:0]    ACTIVE_IDX;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  interrupt_request_controller #(.N_SRC(N), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET), .COMMIT(COMMIT), .IRQ(IRQ), .ACK0(ACK0), .ACK1(ACK1),
    .RETI(RETI), .WR(WR), .RD(RD), .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA),
    .INT0(INT0), .INT1(INT1), .ACTIVE_IDX(ACTIVE_IDX)
  );

  // Reference model: pending/mask as integers, service nesting as a stack
  // (0 = INT0 service, 1 = INT1 service).
  int m_pend, m_mask, m_act_idx, m_act_vld;
  int stk[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [DW-1:0] d);
    ADDR = a; WDATA = d; WR = 1'b1; COMMIT = 1'b1;
    tick();
    WR = 1'b0; COMMIT = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [DW-1:0] d);
    ADDR = a; RD = 1'b1; COMMIT = 1'b1;
    tick();
    RD = 1'b0; COMMIT = 1'b0;
    d = RDATA;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [DW-1:0] d;
    reg_rd(a, d);
    chk(tag, 32'(d), exp);
  endtask

  task automatic pulse(input logic [N-1:0] bits);
    IRQ = bits;
    tick();
    IRQ = '0;
  endtask

  // CPU strobes held for k cycles with COMMIT only in cycle c.
  task automatic held(input logic a0, input logic a1, input logic r, input int k, input int c);
    for (int cyc = 0; cyc < k; cyc++) begin
      ACK0 = a0; ACK1 = a1; RETI = r; COMMIT = (cyc == c);
      tick();
    end
    ACK0 = 1'b0; ACK1 = 1'b0; RETI = 1'b0; COMMIT = 1'b0;
  endtask

  task automatic strobe(input logic a0, input logic a1, input logic r);
    held(a0, a1, r, 1, 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    settle(2);
    RESET = 1'b0;
    tick();
  endtask

  function automatic int lowest(input int v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic void m_ack0();
    if (stk.size() == 0 || (stk.size() == 1 && stk[0] == 1)) begin
      stk.push_back(0);
      m_pend = m_pend & ~1;
    end
  endfunction

  function automatic void m_ack1();
    int mk;
    if (stk.size() == 0) begin
      mk = m_pend & m_mask & 'hFE;
      if (mk != 0) begin
        m_act_idx = lowest(mk);
        m_act_vld = 1;
        m_pend = m_pend & ~(1 << m_act_idx);
      end else begin
        m_act_idx = 0;
        m_act_vld = 0;
      end
      stk.push_back(1);
    end
  endfunction

  function automatic void m_reti();
    int t;
    if (stk.size() > 0) begin
      t = stk.pop_back();
      if (t == 1) m_act_vld = 0;
    end
  endfunction

  initial begin
    int op, v, k, c;
    logic e_int0, e_int1, in_svc0;

    RESET = 1'b1; COMMIT = 1'b0; ACK0 = 1'b0; ACK1 = 1'b0; RETI = 1'b0;
    WR = 1'b0; RD = 1'b0; ADDR = '0; WDATA = '0; IRQ = '0;
    tick();
    chk("rst_int0", 32'(INT0), 0);
    chk("rst_int1", 32'(INT1), 0);
    chk("rst_idx", 32'(ACTIVE_IDX), 0);
    chk("rst_rdata", 32'(RDATA), 0);
    tick();
    RESET = 1'b0;
    tick();
    check_reg("rst_pend", A_PEND, 0);
    check_reg("rst_mask", A_MASK, 0);
    check_reg("rst_active", A_ACTIVE, 0);

    // Single source through a full service, with edge-to-pending latency.
    reg_wr(A_MASK, 16'h0006);
    pulse(8'h04);
    settle(2);
    chk("d1_int1_early", 32'(INT1), 0);
    tick();
    chk("d1_int1_set", 32'(INT1), 1);
    check_reg("d1_pend", A_PEND, 'h0004);
    strobe(1'b0, 1'b1, 1'b0);
    check_reg("d1_active_svc", A_ACTIVE, 'h8002);
    check_reg("d1_pend_clr", A_PEND, 0);
    chk("d1_int1_clr", 32'(INT1), 0);
    chk("d1_idx", 32'(ACTIVE_IDX), 2);
    strobe(1'b0, 1'b0, 1'b1);
    check_reg("d1_active_idle", A_ACTIVE, 'h0002);

    // Simultaneous requests: priority then reassertion.
    pulse(8'h06);
    settle(4);
    strobe(1'b0, 1'b1, 1'b0);
    chk("d2_first", 32'(ACTIVE_IDX), 1);
    strobe(1'b0, 1'b0, 1'b1);
    settle(2);
    chk("d2_reassert", 32'(INT1), 1);
    strobe(1'b0, 1'b1, 1'b0);
    chk("d2_second", 32'(ACTIVE_IDX), 2);
    check_reg("d2_pend", A_PEND, 0);
    strobe(1'b0, 1'b0, 1'b1);

    // Nesting INT0 inside INT1 service.
    reg_wr(A_MASK, 16'h0008);
    pulse(8'h08);
    settle(4);
    strobe(1'b0, 1'b1, 1'b0);
    chk("d3_idx", 32'(ACTIVE_IDX), 3);
    pulse(8'h01);
    settle(4);
    chk("d3_int0_set", 32'(INT0), 1);
    strobe(1'b1, 1'b0, 1'b0);
    tick();
    chk("d3_int0_clr", 32'(INT0), 0);
    strobe(1'b0, 1'b0, 1'b1);
    check_reg("d3_active_nest", A_ACTIVE, 'h8003);
    strobe(1'b0, 1'b0, 1'b1);
    check_reg("d3_active_idle", A_ACTIVE, 'h0003);

    // Held ACK1 with a single COMMIT acts exactly once.
    reg_wr(A_MASK, 16'h0006);
    pulse(8'h06);
    settle(4);
    held(1'b0, 1'b1, 1'b0, 4, 1);
    check_reg("d4_pend", A_PEND, 'h0004);
    check_reg("d4_active", A_ACTIVE, 'h8001);
    strobe(1'b0, 1'b0, 1'b1);
    reg_wr(A_PEND, 16'h00FF);

    // SWTRIG, set-beats-W1C conflict, mask gating.
    reg_wr(A_SWTRIG, 16'h0010);
    check_reg("d5_swtrig_set", A_PEND, 'h0010);
    check_reg("d5_swtrig_rd", A_SWTRIG, 0);
    chk("d5_int1_masked", 32'(INT1), 0);
    reg_wr(A_PEND, 16'h0010);
    check_reg("d5_w1c", A_PEND, 0);
    IRQ = 8'h10;
    tick();
    IRQ = '0;
    tick();
    reg_wr(A_PEND, 16'h0010);
    check_reg("d5_edge_beats_w1c", A_PEND, 'h0010);
    tick();
    chk("d5_int1_still0", 32'(INT1), 0);
    reg_wr(A_MASK, 16'h0010);
    tick();
    chk("d5_int1_unmasked", 32'(INT1), 1);
    reg_wr(3'd5, 16'hFFFF);
    check_reg("d5_bad_addr", 3'd5, 0);
`ifndef INT_LEVEL_MODE_EN
    reg_wr(A_LEVEL, 16'hFFFF);
    check_reg("d5_level_absent", A_LEVEL, 0);
`endif
    reg_wr(A_PEND, 16'h00FF);

    // Reset during nested service.
    reg_wr(A_MASK, 16'h0002);
    pulse(8'h02);
    settle(4);
    strobe(1'b0, 1'b1, 1'b0);
    pulse(8'h01);
    settle(4);
    strobe(1'b1, 1'b0, 1'b0);
    reg_wr(A_SWTRIG, 16'h0021);
    check_reg("d6_mask_pre", A_MASK, 'h0002);
    #2;
    RESET = 1'b1;
    #1;
    chk("d6_int0", 32'(INT0), 0);
    chk("d6_int1", 32'(INT1), 0);
    chk("d6_idx", 32'(ACTIVE_IDX), 0);
    chk("d6_rdata", 32'(RDATA), 0);
    tick();
    RESET = 1'b0;
    tick();
    check_reg("d6_pend", A_PEND, 0);
    check_reg("d6_mask", A_MASK, 0);
    check_reg("d6_active", A_ACTIVE, 0);
    reg_wr(A_MASK, 16'h0002);
    reg_wr(A_SWTRIG, 16'h0002);
    tick();
    chk("d6_idle", 32'(INT1), 1);

`ifdef INT_LEVEL_MODE_EN
    do_reset();
    reg_wr(A_LEVEL, 16'h0002);
    check_reg("lvl_reg", A_LEVEL, 'h0002);
    IRQ = 8'h02;
    settle(4);
    reg_wr(A_PEND, 16'h0002);
    check_reg("lvl_w1c_held", A_PEND, 'h0002);
    IRQ = '0;
    settle(4);
    check_reg("lvl_follow_low", A_PEND, 0);
`endif

    // Randomised operations against the transaction-level model.
    do_reset();
    m_pend = 0; m_mask = 0; m_act_idx = 0; m_act_vld = 0;
    stk.delete();
    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 9));
      v  = int'($urandom_range(0, 255));
      k  = int'($urandom_range(1, 4));
      c  = int'($urandom_range(0, k - 1));
      case (op)
        0, 1: begin pulse(v[N-1:0]); m_pend = m_pend | v; end
        2: begin
          reg_wr(A_MASK, 16'(v));
          m_mask = v;
          check_reg("rnd_mask", A_MASK, 32'(m_mask));
        end
        3: begin reg_wr(A_PEND, 16'(v)); m_pend = m_pend & ~v; end
        4: begin reg_wr(A_SWTRIG, 16'(v)); m_pend = m_pend | v; end
        5: begin held(1'b1, 1'b0, 1'b0, k, c); m_ack0(); end
        6, 7: begin held(1'b0, 1'b1, 1'b0, k, c); m_ack1(); end
        8: begin held(1'b0, 1'b0, 1'b1, k, c); m_reti(); end
        default: begin held(1'b1, 1'b1, 1'b0, k, c); m_ack0(); end
      endcase
      settle(4);
      in_svc0 = 1'b0;
      foreach (stk[j]) if (stk[j] == 0) in_svc0 = 1'b1;
      e_int0 = (m_pend[0] == 1'b1) && !in_svc0;
      e_int1 = ((m_pend & m_mask & 'hFE) != 0) && (stk.size() == 0);
      chk("rnd_int0", 32'(INT0), 32'(e_int0));
      chk("rnd_int1", 32'(INT1), 32'(e_int1));
      chk("rnd_idx", 32'(ACTIVE_IDX), 32'(m_act_idx));
      check_reg("rnd_pend", A_PEND, 32'(m_pend & 'hFF));
      check_reg("rnd_active", A_ACTIVE, 32'((m_act_vld << 15) | m_act_idx));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
